// File: rtl/alu_issue_ctrl.sv
// Issue controller for a combinational ALU: accepts instruction words, reads an
// 8x16 register file, drives the ALU and retires results into regs/pc/flags.
module alu_issue_ctrl #(
  parameter int PC_W = 8,
  parameter int NREG = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            instr_valid,
  input  logic [15:0]     instr_data,
  output logic            instr_ready,
  output logic [15:0]     alu_a,
  output logic [15:0]     alu_b,
  output logic [3:0]      alu_s,
  input  logic [15:0]     alu_f,
  input  logic            alu_take_branch,
  input  logic            alu_ovf,
  input  logic            clr_flags,
  output logic [PC_W-1:0] pc,
  output logic            done,
  output logic            ovf_sticky,
  output logic            illegal,
  input  logic [2:0]      dbg_addr,
  output logic [15:0]     dbg_data
);

  // state | meaning
  // IDLE  | ready for a new instruction word
  // EXEC  | ALU driven from latched word; results captured at the edge
  // WB    | writeback, pc update, flag update, done pulse
  typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

  state_t state, state_nx;

  logic [15:0] instr_q;
  logic [15:0] rf [NREG];
  logic [15:0] f_q;
  logic        ovf_q;
  logic        br_q;

  logic [3:0]  op;
  logic        imm;
  logic [2:0]  rd;
  logic [2:0]  rs;
  logic [4:0]  lo;
  logic [15:0] ext_lo;
  logic [15:0] rs_val;
  logic [15:0] rb_val;
  logic        wr_en;
  logic        is_branch;
  logic [PC_W-1:0] br_off;

  assign op  = instr_q[15:12];
  assign imm = instr_q[11];
  assign rd  = instr_q[10:8];
  assign rs  = instr_q[7:5];
  assign lo  = instr_q[4:0];

  // shift amounts are unsigned; every other immediate is a signed 5-bit value
  assign ext_lo = (op == 4'd4 || op == 4'd5) ? {11'b0, lo} : {{11{lo[4]}}, lo};
  assign rs_val = (rs == 3'd0) ? 16'h0000 : rf[rs];
  assign rb_val = (lo[4:2] == 3'd0) ? 16'h0000 : rf[lo[4:2]];

  assign alu_a = rs_val;
  assign alu_b = imm ? ext_lo : rb_val;
  assign alu_s = op;

  assign wr_en     = (op <= 4'd5) || (op == 4'd8);
  assign is_branch = (op == 4'd6) || (op == 4'd7);
  assign br_off    = {{(PC_W-5){lo[4]}}, lo};

  assign dbg_data = (dbg_addr == 3'd0) ? 16'h0000 : rf[dbg_addr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    instr_ready = 1'b0;
    case (state)
      IDLE: begin
        instr_ready = 1'b1;
        if (instr_valid) state_nx = EXEC;
      end
      EXEC:    state_nx = WB;
      WB:      state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q    <= '0;
      f_q        <= '0;
      ovf_q      <= 1'b0;
      br_q       <= 1'b0;
      pc         <= '0;
      done       <= 1'b0;
      ovf_sticky <= 1'b0;
      illegal    <= 1'b0;
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE && instr_valid) instr_q <= instr_data;
      if (state == EXEC) begin
        f_q   <= alu_f;
        ovf_q <= alu_ovf;
        br_q  <= alu_take_branch;
      end
      if (clr_flags) begin
        ovf_sticky <= 1'b0;
        illegal    <= 1'b0;
      end
      // flag sets come after the clear so a simultaneous set wins
      if (state == WB) begin
        done <= 1'b1;
        if (wr_en && rd != 3'd0) rf[rd] <= f_q;
        if (is_branch && br_q) pc <= pc + br_off;
        else                   pc <= pc + PC_W'(1);
        if (op == 4'd0 && ovf_q) ovf_sticky <= 1'b1;
        if (op >= 4'd9)          illegal    <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: ALU stub, directed vector table, multi-cycle
// sequences and random instructions against an instruction-level model.
`timescale 1ns/100ps
module tb_alu_issue_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        instr_valid = 1'b0;
  logic [15:0] instr_data = 16'h0;
  logic        instr_ready;
  logic [15:0] alu_a, alu_b, alu_f;
  logic [3:0]  alu_s;
  logic        alu_take_branch, alu_ovf;
  logic        clr_flags = 1'b0;
  logic [7:0]  pc;
  logic        done, ovf_sticky, illegal;
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;

  int checks = 0;
  int failures = 0;

  alu_issue_ctrl #(.PC_W(8), .NREG(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr_data(instr_data), .instr_ready(instr_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s),
    .alu_f(alu_f), .alu_take_branch(alu_take_branch), .alu_ovf(alu_ovf),
    .clr_flags(clr_flags), .pc(pc), .done(done),
    .ovf_sticky(ovf_sticky), .illegal(illegal),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // ALU stub; non-meaningful outputs are driven to values that would expose misuse
  always_comb begin
    alu_f = 16'hA5A5;
    alu_ovf = 1'b1;
    alu_take_branch = 1'b1;
    case (alu_s)
      4'd0: begin
        alu_f = alu_a + alu_b;
        alu_ovf = (alu_a[15] == alu_b[15]) && (alu_f[15] != alu_a[15]);
      end
      4'd1: begin
        alu_f = alu_a - alu_b;
        alu_ovf = (alu_a[15] != alu_b[15]) && (alu_f[15] != alu_a[15]);
      end
      4'd2: alu_f = alu_a & alu_b;
      4'd3: alu_f = alu_a | alu_b;
      4'd4: alu_f = 16'($signed(alu_a) >>> alu_b[3:0]);
      4'd5: alu_f = alu_a << alu_b[3:0];
      4'd6: alu_take_branch = (alu_a == 16'h0);
      4'd7: alu_take_branch = (alu_a != 16'h0);
      4'd8: alu_f = alu_a ^ alu_b;
      default: alu_f = 16'hBEEF;
    endcase
  end

  // instruction-level reference state
  logic [15:0] m_r [8];
  int          m_pc;
  bit          m_ovf, m_ill;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_r[i] = 16'h0;
    m_pc = 0; m_ovf = 0; m_ill = 0;
  endtask

  task automatic model_exec(input logic [15:0] ins, input bit clr_held);
    int op, rd, rs, lo, off, sa, sb, sum, sh, next_pc;
    logic [15:0] a, b, res;
    bit wr;
    op = ins[15:12]; rd = ins[10:8]; rs = ins[7:5]; lo = ins[4:0];
    off = (lo >= 16) ? lo - 32 : lo;
    a = m_r[rs];
    if (ins[11]) b = (op == 4 || op == 5) ? 16'(lo) : 16'(off);
    else         b = m_r[lo / 4];
    sa = int'($signed(a)); sb = int'($signed(b)); sh = b % 16;
    if (clr_held) begin m_ovf = 0; m_ill = 0; end
    wr = 1; res = 16'h0; next_pc = m_pc + 1;
    case (op)
      0: begin sum = sa + sb; res = 16'(sum); if (sum > 32767 || sum < -32768) m_ovf = 1; end
      1: res = a - b;
      2: res = a & b;
      3: res = a | b;
      4: res = 16'(sa >>> sh);
      5: res = a << sh;
      6: begin wr = 0; if (a == 0) next_pc = m_pc + off; end
      7: begin wr = 0; if (a != 0) next_pc = m_pc + off; end
      8: res = a ^ b;
      default: begin wr = 0; m_ill = 1; end
    endcase
    if (wr && rd != 0) m_r[rd] = res;
    m_pc = ((next_pc % 256) + 256) % 256;
  endtask

  task automatic compare_all(input string tag);
    chk($sformatf("%s_pc", tag), pc, m_pc);
    chk($sformatf("%s_ovf", tag), ovf_sticky, m_ovf);
    chk($sformatf("%s_ill", tag), illegal, m_ill);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = 3'(i);
      #0.5;
      chk($sformatf("%s_r%0d", tag, i), dbg_data, m_r[i]);
    end
  endtask

  // issue one instruction, check latency and retire state against the model
  task automatic run_instr(input logic [15:0] ins, input bit hold_clr, input string tag);
    int n;
    n = 0;
    while (!instr_ready && n < 10) begin @(negedge clk); n++; end
    chk($sformatf("%s_ready", tag), instr_ready, 1);
    instr_valid = 1'b1; instr_data = ins; clr_flags = hold_clr;
    @(posedge clk); #1;
    instr_valid = 1'b0; instr_data = 16'($urandom);
    n = 0;
    do begin @(negedge clk); n++; end while (!done && n < 8);
    chk($sformatf("%s_latency", tag), n, 3);
    clr_flags = 1'b0;
    model_exec(ins, hold_clr);
    compare_all(tag);
    @(negedge clk);
    chk($sformatf("%s_done_pulse", tag), done, 0);
  endtask

  typedef struct {
    logic [15:0] ins;
    bit          pre_clr;
    logic [2:0]  ra;
    logic [15:0] rv;
    logic [7:0]  pcv;
    bit          ovf;
    bit          ill;
  } vec_t;

  function automatic vec_t mk(input logic [15:0] ins, input bit pc_clr, input logic [2:0] ra,
                              input logic [15:0] rv, input logic [7:0] pcv, input bit ovf, input bit ill);
    vec_t v;
    v.ins = ins; v.pre_clr = pc_clr; v.ra = ra; v.rv = rv; v.pcv = pcv; v.ovf = ovf; v.ill = ill;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[$];
    logic [15:0] tq[4];
    int acc_cyc[$];
    int idx, retired, dcount;
    bit acc_now;

    vecs.push_back(mk(16'h0905, 0, 3'd1, 16'h0005, 8'd1, 0, 0));
    vecs.push_back(mk(16'h0901, 0, 3'd1, 16'h0001, 8'd2, 0, 0));
    for (int k = 1; k <= 14; k++)
      vecs.push_back(mk(16'h5921, 0, 3'd1, 16'(1 << k), 8'(2 + k), 0, 0));
    vecs.push_back(mk(16'h0224, 0, 3'd2, 16'h8000, 8'd17, 1, 0));
    vecs.push_back(mk(16'h6803, 1, 3'd2, 16'h8000, 8'd20, 0, 0));
    vecs.push_back(mk(16'h7803, 0, 3'd1, 16'h4000, 8'd21, 0, 0));
    vecs.push_back(mk(16'hF000, 0, 3'd1, 16'h4000, 8'd22, 0, 1));
    vecs.push_back(mk(16'h7E3F, 0, 3'd6, 16'h0000, 8'd21, 0, 1));

    // reset values
    #2;
    chk("rst_ready", instr_ready, 1);
    chk("rst_pc", pc, 0);
    chk("rst_done", done, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_alu_s", alu_s, 0);
    chk("rst_ovf", ovf_sticky, 0);
    chk("rst_ill", illegal, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    // directed vector table
    foreach (vecs[i]) begin
      if (vecs[i].pre_clr) begin
        clr_flags = 1'b1;
        @(posedge clk); #1; clr_flags = 1'b0;
        m_ovf = 0; m_ill = 0;
        @(negedge clk);
        chk($sformatf("vec%0d_clr_ovf", i), ovf_sticky, 0);
      end
      run_instr(vecs[i].ins, 0, $sformatf("vec%0d", i));
      dbg_addr = vecs[i].ra; #0.5;
      chk($sformatf("vec%0d_reg", i), dbg_data, vecs[i].rv);
      chk($sformatf("vec%0d_pcv", i), pc, vecs[i].pcv);
      chk($sformatf("vec%0d_ovfv", i), ovf_sticky, vecs[i].ovf);
      chk($sformatf("vec%0d_illv", i), illegal, vecs[i].ill);
    end

    // clear held across an overflowing ADD: set wins in WB, illegal cleared
    run_instr(16'h0224, 1, "setwins");
    chk("setwins_ovf_const", ovf_sticky, 1);
    chk("setwins_ill_const", illegal, 0);

    // back-to-back issue with instr_valid held high
    tq[0] = 16'h0C81; tq[1] = 16'h0C82; tq[2] = 16'h0C83; tq[3] = 16'h0C84;
    idx = 0; retired = 0;
    instr_valid = 1'b1; instr_data = tq[0];
    for (int c = 0; c < 24 && retired < 4; c++) begin
      if (done) begin model_exec(tq[retired], 0); retired++; end
      acc_now = instr_ready && instr_valid;
      if (acc_now) acc_cyc.push_back(c);
      @(posedge clk); #1;
      if (acc_now) begin
        idx++;
        if (idx < 4) instr_data = tq[idx];
        else instr_valid = 1'b0;
      end
      @(negedge clk);
    end
    instr_valid = 1'b0;
    chk("tput_accepts", acc_cyc.size(), 4);
    chk("tput_retired", retired, 4);
    for (int i = 1; i < acc_cyc.size(); i++)
      chk($sformatf("tput_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 3);
    compare_all("tput");

    // reset asserted during EXEC
    @(negedge clk);
    instr_valid = 1'b1; instr_data = 16'h0B07;
    @(posedge clk); #1; instr_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_pc", pc, 0);
    chk("mrst_done", done, 0);
    chk("mrst_ready", instr_ready, 1);
    chk("mrst_alu_a", alu_a, 0);
    chk("mrst_alu_b", alu_b, 0);
    chk("mrst_alu_s", alu_s, 0);
    chk("mrst_ovf", ovf_sticky, 0);
    dbg_addr = 3'd4; #0.5;
    chk("mrst_r4", dbg_data, 0);
    model_reset();
    @(negedge clk); rst_n = 1'b1;
    dcount = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (done) dcount++; end
    chk("mrst_no_retire", dcount, 0);
    compare_all("mrst");

    // pc wrap in both directions
    run_instr(16'h681F, 0, "wrap_back");
    chk("wrap_back_pc", pc, 8'hFF);
    run_instr(16'h0801, 0, "wrap_fwd");
    chk("wrap_fwd_pc", pc, 8'h00);

    // random instructions against the model
    for (int i = 0; i < 60; i++) begin
      logic [15:0] ins;
      ins = 16'($urandom);
      ins[15:12] = ($urandom % 4 == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      run_instr(ins, ($urandom % 8 == 0), $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
